seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter and the transmit-side counterpart of the team's serial sequence detector. It serializes a PAT_W-bit pattern (default 1011) MSB first, one bit per enabled clock. The pattern can be repeated back-to-back a programmable number of times. It drives the detector's d/en inputs in loopback benches and feeds downstream serial links. A thermometer progress output matches the detector's completion encoding bit-for-bit.

Parameters:
PAT_W, 4, pattern width in bits (2..16)
CNT_W, 4, width of repeat-count input
DEF_PAT, 4'b1011, pattern loaded when pattern input is zero at start (PAT_W wide)

Ports:
clk  in  1  single system clock, rising edge
rst_  in  1  asynchronous, active-low reset
en  in  1  clock enable; when 0 every register holds
start  in  1  request to send; sampled only in IDLE with en=1
pattern  in  PAT_W  pattern to send, captured on start accept
reps  in  CNT_W  extra frames; frames sent = reps+1
dout  out  1  serial data bit
dout_vld  out  1  dout carries a pattern (or parity) bit
busy  out  1  frame sequence in progress
done  out  1  one-enabled-cycle pulse after the final bit
progress  out  PAT_W  thermometer: bits of current frame emitted

Behaviour:
- Reset (async, rst_=0): state=IDLE; dout=0, dout_vld=0, busy=0, done=0, progress=0. Pending frames are discarded. This also applies mid-frame.
- Everything is registered; no combinational path from inputs to outputs.
- The FSM advances only on clk edges with en=1. With en=0 all outputs hold their last value, done included.
- States:
  - IDLE: busy=0, dout_vld=0, progress=0.
  - On start=1 && en=1: capture pattern into a shadow register. A zero pattern is replaced by DEF_PAT. Load frame counter=reps. Go to SEND.
- SEND entry: on the next edge, dout=shadow[PAT_W-1], dout_vld=1, busy=1, progress=0..01.
- Bit k of a frame (k=0 is the MSB) appears on the k-th enabled cycle after entry. During bit k, progress=(1<<(k+1))-1.
- After bit PAT_W-1 (progress all-ones), with frame counter>0:
  - decrement the counter;
  - the next enabled cycle carries bit 0 of the same shadow pattern, with no gap;
  - progress restarts at 0..01.
- After bit PAT_W-1 with frame counter=0: the next enabled edge goes to IDLE with done=1, dout_vld=0, dout=0, busy=0.
- done clears on the following enabled edge.
- A start seen in the same cycle as done is accepted; the new frame's bit 0 follows one cycle later.
- start while busy is ignored. pattern and reps changes while busy are ignored; the shadow copies are used.
- Latency: start accept to first bit = 1 enabled cycle.
- Total bits = (reps+1)*PAT_W. Without the parity option the done pulse occurs exactly that many enabled cycles after the first bit.
- Frame counter width is CNT_W. reps = all-ones must produce 2^CNT_W frames without wrapping early.

Optional Feature:
Macro SEQ_GEN_PARITY_EN.
- When defined: each frame is followed by one parity slot before the next frame or done.
  - dout = ~^shadow (odd parity), dout_vld=1.
  - progress holds all-ones during the slot.
  - An extra output par_slot (1 bit, reset 0) is high during that slot only.
  - Bits per frame become PAT_W+1.
- When undefined: no parity slot and no par_slot port; frames run back-to-back exactly as described above.

Decomposition:
- Package seq_gen_pkg holds:
  - the state enum (IDLE, SEND, and PARITY when the option is on);
  - the DEF_PAT default constant 4'b1011;
  - a thermometer(k) function returning (1<<(k+1))-1.
- One sub-module is natural: seq_piso, a PAT_W-bit parallel-load, MSB-first shift register with load/shift/enable. The top-level holds the FSM, bit counter and frame counter.

Test Plan:
- Reset: hold rst_=0 with start=1 toggling -> dout, dout_vld, busy, done, progress all 0. Release -> still IDLE.
- Single frame: pattern=1011, reps=0, start one cycle -> cycles 1-4 give dout=1,0,1,1, progress=0001,0011,0111,1111. Cycle 5 gives done=1, busy=0.
- Repeat and loopback: reps=2, dout driving detector d with shared en -> 12 contiguous bits 1011 1011 1011. Detector's detected rises after bits 4, 8 and 12. Exactly one done pulse occurs.
- Enable stall: deassert en for 3 cycles after bit 1 -> outputs frozen at dout=0, progress=0011. Resume continues with bit 2=1.
- Ignored start: restart with pattern=0110 during busy -> the original 1011 sequence completes unchanged. A zero pattern at start -> DEF_PAT 1011 is emitted.
- Mid-frame reset: rst_ low asynchronously during bit 2 -> outputs clear immediately, before the next clk edge. A new start then sends from bit 0. With SEQ_GEN_PARITY_EN, pattern 1011 produces a parity bit of 0 with par_slot=1 after bit 3.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
// SEQ_GEN_PARITY_EN adds the PARITY state used for the per-frame odd-parity slot.
package seq_gen_pkg;

  localparam int unsigned MAX_PAT_W   = 16;
  localparam logic [3:0]  SEQ_DEF_PAT = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1
`ifdef SEQ_GEN_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } state_e;

  // Returns (1 << (k+1)) - 1 without overflowing the shift at the top width.
  function automatic logic [MAX_PAT_W-1:0] thermometer(input int unsigned k);
    logic [MAX_PAT_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
      t[i] = (i <= k);
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; load wins over shift, en gates both.
module seq_piso #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        sr_q <= din_i;
      end else if (shift_i) begin
        sr_q <= {sr_q[W-2:0], 1'b0};
      end
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends (reps+1) copies of a captured pattern MSB first.
// Define SEQ_GEN_PARITY_EN to append an odd-parity slot (and par_slot_o) after each frame.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] reps_i,
  output logic             dout_o,
  output logic             dout_vld_o,
  output logic             busy_o,
  output logic             done_o,
`ifdef SEQ_GEN_PARITY_EN
  output logic             par_slot_o,
`endif
  output logic [PAT_W-1:0] progress_o
);

  localparam int unsigned      BIT_W    = $clog2(PAT_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  // Bit index PAT_W marks "all frames sent, emit done on the next edge".
  localparam logic [BIT_W-1:0] END_BIT  = BIT_W'(PAT_W);

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic               dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PAT_W-1:0]   prog_q, prog_d;
`ifdef SEQ_GEN_PARITY_EN
  logic               par_q, par_d;
`endif
  logic               piso_load, piso_shift, piso_msb, frame_end;
  logic [PAT_W-1:0]   piso_din;

  seq_piso #(.W(PAT_W)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .din_i   (piso_din),
    .msb_o   (piso_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      dout_q   <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prog_q   <= '0;
`ifdef SEQ_GEN_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (en_i) begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prog_q   <= prog_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next state and next outputs; the _d outputs describe what appears after this edge.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    shadow_d   = shadow_q;
    dout_d     = 1'b0;
    vld_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    prog_d     = '0;
`ifdef SEQ_GEN_PARITY_EN
    par_d      = 1'b0;
`endif
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shadow_d  = (pattern_i == '0) ? DEF_PAT : pattern_i;
          frame_d   = reps_i;
          bit_d     = '0;
          piso_load = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_q == END_BIT) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dout_d     = piso_msb;
          vld_d      = 1'b1;
          busy_d     = 1'b1;
          prog_d     = PAT_W'(thermometer(32'(bit_q)));
          piso_shift = 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef SEQ_GEN_PARITY_EN
            state_d = ST_PARITY;
`else
            frame_end = 1'b1;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: begin
        dout_d    = ~^shadow_q;
        vld_d     = 1'b1;
        busy_d    = 1'b1;
        prog_d    = '1;
        par_d     = 1'b1;
        state_d   = ST_SEND;
        frame_end = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Reload the shadow pattern for another frame, or arm the done cycle.
    if (frame_end) begin
      if (frame_q != '0) begin
        frame_d   = frame_q - CNT_W'(1);
        bit_d     = '0;
        piso_load = 1'b1;
      end else begin
        bit_d = END_BIT;
      end
    end
    piso_din = shadow_d;
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign progress_o = prog_q;
`ifdef SEQ_GEN_PARITY_EN
  assign par_slot_o = par_q;
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: stream-level model plus directed literal checks.
module tb_seq_pattern_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif

  typedef struct packed {
    logic       dout;
    logic       vld;
    logic       busy;
    logic       done;
    logic       par;
    logic [3:0] prog;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, start;
  logic [3:0] pattern, reps;
  logic       dout, dout_vld, busy, done, par_slot;
  logic [3:0] progress;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t exp_cur = '0;
  logic edge_en = 1'b0;
  logic cap[$];
  int   n_done = 0;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .start_i    (start),
    .pattern_i  (pattern),
    .reps_i     (reps),
    .dout_o     (dout),
    .dout_vld_o (dout_vld),
    .busy_o     (busy),
    .done_o     (done),
`ifdef SEQ_GEN_PARITY_EN
    .par_slot_o (par_slot),
`endif
    .progress_o (progress)
  );

`ifndef SEQ_GEN_PARITY_EN
  assign par_slot = 1'b0;
`endif

  // Expected output sequence for one accepted start: latency slot, frames, done.
  task automatic push_seq(input logic [3:0] p, input logic [3:0] r);
    exp_t       e;
    logic [3:0] sp;
    sp = (p == 4'd0) ? 4'b1011 : p;
    q.push_back(exp_t'(0));
    for (int f = 0; f <= int'(r); f++) begin
      for (int k = 0; k < 4; k++) begin
        e = '0;
        e.dout = sp[3-k];
        e.vld  = 1'b1;
        e.busy = 1'b1;
        e.prog = 4'((1 << (k + 1)) - 1);
        q.push_back(e);
      end
`ifdef SEQ_GEN_PARITY_EN
      e = '0;
      e.dout = ~^sp;
      e.vld  = 1'b1;
      e.busy = 1'b1;
      e.par  = 1'b1;
      e.prog = 4'hF;
      q.push_back(e);
`endif
    end
    e = '0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_cur = '0;
      edge_en = 1'b0;
    end else begin
      edge_en = en;
      if (en) begin
        if (start && q.size() == 0) push_seq(pattern, reps);
        exp_cur = (q.size() != 0) ? q.pop_front() : exp_t'(0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t act;
    if (rst_n) begin
      act = '{dout: dout, vld: dout_vld, busy: busy, done: done, par: par_slot, prog: progress};
      n_chk++;
      if (act !== exp_cur) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got=%b required=%b", $time, act, exp_cur);
      end
      if (edge_en && dout_vld) cap.push_back(dout);
      if (edge_en && done) n_done++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [3:0] p, input logic [3:0] r);
    pattern = p;
    reps    = r;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
  endtask

  function automatic logic [63:0] cap_bits();
    logic [63:0] v;
    v = '0;
    foreach (cap[i]) v = {v[62:0], cap[i]};
    return v;
  endfunction

  initial begin
    rst_n = 1'b1; en = 1'b1; start = 1'b0; pattern = '0; reps = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      start = ~start;
      chk("rst_outs", {60'd0, dout, dout_vld, busy, done}, 64'd0);
      chk("rst_prog", 64'(progress), 64'd0);
    end
    start = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single frame with literal bit/progress expectations
    send(4'b1011, 4'd0);
    chk("lat_vld", 64'(dout_vld), 64'd0);
    cyc(1); chk("b0", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b0001});
    chk("b0_busy", 64'(busy), 64'd1);
    cyc(1); chk("b1", {59'd0, dout, progress}, {59'd0, 1'b0, 4'b0011});
    cyc(1); chk("b2", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b0111});
    cyc(1); chk("b3", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b1111});
`ifdef SEQ_GEN_PARITY_EN
    cyc(1); chk("par", {58'd0, par_slot, dout, progress}, {58'd0, 1'b1, 1'b0, 4'b1111});
`endif
    cyc(1); chk("done", {61'd0, done, busy, dout_vld}, {61'd0, 1'b1, 1'b0, 1'b0});
    cyc(1); chk("done_clr", 64'(done), 64'd0);

    // Three back-to-back frames, one done pulse
    cap.delete(); n_done = 0;
    send(4'b1011, 4'd2);
    cyc(3 * FB + 4);
    chk("rep_len", 64'(cap.size()), 64'(3 * FB));
`ifdef SEQ_GEN_PARITY_EN
    chk("rep_bits", cap_bits(), 64'b101101011010110);
`else
    chk("rep_bits", cap_bits(), 64'b101110111011);
`endif
    chk("rep_done", 64'(n_done), 64'd1);

    // Start during last slot is ignored; start during done is accepted
    send(4'b1011, 4'd0);
    cyc(FB);
    pattern = 4'b0110; start = 1'b1;
    cyc(1); chk("dc_done", 64'(done), 64'd1);
    cyc(1); start = 1'b0;
    chk("dc_lat", {62'd0, done, dout_vld}, 64'd0);
    cyc(1); chk("dc_b0", {59'd0, dout, progress}, {59'd0, 1'b0, 4'b0001});
    cyc(1); chk("dc_b1", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b0011});
    cyc(FB + 2);

    // Enable stall after bit 1
    send(4'b1011, 4'd0);
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall", {59'd0, dout, progress}, {59'd0, 1'b0, 4'b0011});
    end
    en = 1'b1;
    cyc(1); chk("resume", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b0111});
    cyc(FB + 2);

    // Pattern/reps changes and restart while busy are ignored
    cap.delete();
    send(4'b1011, 4'd1);
    cyc(2);
    pattern = 4'b0110; reps = 4'd0; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(2 * FB + 2);
`ifdef SEQ_GEN_PARITY_EN
    chk("ign_bits", cap_bits(), 64'b1011010110);
`else
    chk("ign_bits", cap_bits(), 64'b10111011);
`endif

    // Zero pattern falls back to the default
    cap.delete();
    send(4'b0000, 4'd0);
    cyc(FB + 3);
`ifdef SEQ_GEN_PARITY_EN
    chk("def_bits", cap_bits(), 64'b10110);
`else
    chk("def_bits", cap_bits(), 64'b1011);
`endif

    // All-ones reps: 16 frames
    cap.delete(); n_done = 0;
    send(4'b0110, 4'hF);
    cyc(16 * FB + 4);
    chk("max_len", 64'(cap.size()), 64'(16 * FB));
    chk("max_done", 64'(n_done), 64'd1);

    // Asynchronous reset during bit 2
    send(4'b1011, 4'd0);
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk("arst_outs", {55'd0, dout, dout_vld, busy, done, par_slot, progress}, 64'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    send(4'b1011, 4'd0);
    cyc(1); chk("arst_b0", {59'd0, dout, progress}, {59'd0, 1'b1, 4'b0001});
    cyc(FB + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
